// File: rtl/reset_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer.
//   rs_state_t : sequencer FSM states
//   DOM_*      : domain indices in release order (memory, GEMM, core)
// ----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RELEASE = 3'd1,
        WAIT    = 3'd2,
        GAP     = 3'd3,
        RUN     = 3'd4
    } rs_state_t;

    localparam int DOM_MEM  = 0;
    localparam int DOM_GEMM = 1;
    localparam int DOM_CORE = 2;

endpackage

// File: rtl/reset_sequencer_sync.sv
// ----------------------------------------------------------------------------
// sync_ff
// Multi-flop level synchronizer for an asynchronous input.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, flops clear to 0
//   d_i  : asynchronous level input
//   q_o  : synchronized level, STAGES clk edges behind d_i
// ----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: d_i enters at bit 0, the oldest sample leaves at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
// Releases per-domain resets in index order once the (synchronized) reset
// request has been low for MIN_HOLD cycles. Each release waits for that
// domain's init-done or a timeout, followed by a settle gap.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   rst_req_i     : stretched reset request, asynchronous level
//   init_done_i   : per-domain init complete (clk domain, level)
//   dom_rst_o     : per-domain reset, active-high
//   ready_o       : all domains released and settled
//   timeout_err_o : sticky per-domain timeout flag for the last sequence
//   rst_count_o   : saturating count of synchronized rst_req rising edges
// ----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_HOLD       = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rst_req_i,
    input  logic [NUM_DOMAINS-1:0] init_done_i,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic                   ready_o,
    output logic [NUM_DOMAINS-1:0] timeout_err_o,
    output logic [CNT_W-1:0]       rst_count_o
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic                   req_s;
    logic                   req_prev_q;
    logic                   rise_s;
    rs_state_t              state_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] dom_rst_q;
    logic                   ready_q;
    logic [NUM_DOMAINS-1:0] timeout_err_q;
    logic [CNT_W-1:0]       rst_count_q;
    logic [CNT_W-1:0]       rst_count_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rst_req_i),
        .q_o (req_s)
    );

    assign rise_s = req_s & ~req_prev_q;

    // Edge-detect register for the synchronized request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_s;
        end
    end

    // Saturating next value of the reset-event counter.
    always_comb begin
        if (rise_s && (rst_count_q != {CNT_W{1'b1}})) begin
            rst_count_d = rst_count_q + CNT_W'(1);
        end else begin
            rst_count_d = rst_count_q;
        end
    end

    // Reset-event counter register; only the hard reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_count_q <= '0;
        end else begin
            rst_count_q <= rst_count_d;
        end
    end

    // Sequencer FSM with its counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            dom_rst_q     <= '1;
            ready_q       <= 1'b0;
            timeout_err_q <= '0;
        end else if (req_s) begin
            // A live request restarts from scratch in every state; it also
            // wins over a timeout landing on the same edge.
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            dom_rst_q     <= '1;
            ready_q       <= 1'b0;
            timeout_err_q <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    dom_rst_q <= '1;
                    ready_q   <= 1'b0;
                    if (hold_cnt_q == HOLD_W'(MIN_HOLD - 1)) begin
                        hold_cnt_q <= '0;
                        idx_q      <= '0;
                        state_q    <= RELEASE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    dom_rst_q[idx_q] <= 1'b0;
                    wait_cnt_q       <= '0;
                    state_q          <= WAIT;
                end
                WAIT: begin
                    if (init_done_i[idx_q]) begin
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on this domain but leave it released.
                        timeout_err_q[idx_q] <= 1'b1;
                        gap_cnt_q            <= '0;
                        state_q              <= GAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt_q <= '0;
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            ready_q   <= 1'b1;
                            dom_rst_q <= '0;
                            state_q   <= RUN;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= RELEASE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    ready_q   <= 1'b1;
                    dom_rst_q <= '0;
                end
                default: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= '0;
                    idx_q      <= '0;
                    dom_rst_q  <= '1;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dom_rst_o     = dom_rst_q;
    assign ready_o       = ready_q;
    assign timeout_err_o = timeout_err_q;
    assign rst_count_o   = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench. The stimulus process computes, from the release rules,
// the clock edge and output value of every expected output change and queues
// it; a monitor pops and compares whenever the DUT outputs change.
// A second instance with CNT_W=2 checks counter saturation.
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int MINH = 4;
    localparam int GAPC = 8;
    localparam int TMO  = 256;

    typedef struct {
        int         cyc;
        logic [2:0] dom;
        logic       rdy;
        logic [2:0] err;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_req_i;
    logic [2:0] init_done_i;
    logic [2:0] dom_rst_o;
    logic       ready_o;
    logic [2:0] timeout_err_o;
    logic [7:0] rst_count_o;
    logic [2:0] dom_rst2;
    logic       ready2;
    logic [2:0] err2;
    logic [1:0] cnt2;

    int  cyc = 0;
    int  checks = 0;
    int  fails = 0;
    int  n_model = 0;
    int  n2_model = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];
    int  q2[$];

    reset_sequencer dut (
        .clk(clk), .rst(rst), .rst_req_i(rst_req_i), .init_done_i(init_done_i),
        .dom_rst_o(dom_rst_o), .ready_o(ready_o), .timeout_err_o(timeout_err_o),
        .rst_count_o(rst_count_o)
    );

    reset_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rst_req_i(rst_req_i), .init_done_i(init_done_i),
        .dom_rst_o(dom_rst2), .ready_o(ready2), .timeout_err_o(err2),
        .rst_count_o(cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [2:0] d, input logic r, input logic [2:0] e);
        ev_t ev;
        ev.cyc = c;
        ev.dom = d;
        ev.rdy = r;
        ev.err = e;
        ev.cnt = 8'(n_model);
        exp_q.push_back(ev);
    endtask

    // Request seen high after edge p: everything scheduled from the reaction
    // edge onward is cancelled, resets reassert and the counter steps.
    task automatic rise_at(input int p);
        int e;
        e = p + SYNC + 1;
        while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
        if (n_model < 255) n_model++;
        push_ev(e, 3'b111, 1'b0, 3'b000);
        n2_model++;
        if (n2_model <= 3) q2.push_back(n2_model);
    endtask

    // Request seen low after edge p: schedule the whole release sequence.
    task automatic fall_at(input int p, input logic [2:0] done);
        int         r;
        int         w;
        logic [2:0] dom;
        logic [2:0] err;
        r   = p + SYNC + MINH + 1;
        dom = 3'b111;
        err = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dom[i] = 1'b0;
            push_ev(r, dom, 1'b0, err);
            w = done[i] ? 1 : TMO;
            if (!done[i]) begin
                err[i] = 1'b1;
                push_ev(r + TMO, dom, 1'b0, err);
            end
            if (i < 2) r = r + w + GAPC + 1;
            else push_ev(r + w + GAPC, 3'b000, 1'b1, err);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL idle_timeout: %0d expected changes never seen, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic check_reset();
        chk("rst_dom_rst", int'(dom_rst_o), 7);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_timeout_err", int'(timeout_err_o), 0);
        chk("rst_count", int'(rst_count_o), 0);
        chk("rst_count_sat_inst", int'(cnt2), 0);
    endtask

    // One request pulse of 'hold' cycles; abort_after<0 lets it finish,
    // otherwise the next request follows that many cycles after the fall.
    task automatic do_seq(input int hold, input logic [2:0] done, input int abort_after);
        @(posedge clk); #1;
        rst_req_i = 1'b1;
        rise_at(cyc);
        repeat (hold) @(posedge clk);
        #1;
        init_done_i = done;
        rst_req_i   = 1'b0;
        fall_at(cyc, done);
        if (abort_after < 0) wait_idle();
        else repeat (abort_after) @(posedge clk);
    endtask

    // Monitor: any change of the observed outputs must match the next queued event.
    initial begin
        logic [15:0] cur;
        logic [15:0] prev;
        logic [1:0]  prev2;
        ev_t         e;
        int          w2;
        prev  = '0;
        prev2 = '0;
        forever begin
            @(negedge clk);
            cur = {dom_rst_o, ready_o, timeout_err_o, rst_count_o, 1'b0};
            if (mon_en && cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change @%0d: dom=%b rdy=%b err=%b cnt=%0d, required no change",
                             cyc, dom_rst_o, ready_o, timeout_err_o, rst_count_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.dom !== dom_rst_o || e.rdy !== ready_o ||
                        e.err !== timeout_err_o || e.cnt !== rst_count_o) begin
                        fails++;
                        $display("FAIL output_event: got cyc=%0d dom=%b rdy=%b err=%b cnt=%0d, required cyc=%0d dom=%b rdy=%b err=%b cnt=%0d",
                                 cyc, dom_rst_o, ready_o, timeout_err_o, rst_count_o,
                                 e.cyc, e.dom, e.rdy, e.err, e.cnt);
                    end
                end
            end
            if (mon_en && cnt2 !== prev2) begin
                checks++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL sat_count_change: got %0d, required no change", cnt2);
                end else begin
                    w2 = q2.pop_front();
                    if (int'(cnt2) != w2) begin
                        fails++;
                        $display("FAIL sat_count: got %0d required %0d", cnt2, w2);
                    end
                end
            end
            prev  = cur;
            prev2 = cnt2;
        end
    end

    initial begin
        logic [2:0] d;
        int         hold;
        int         ab;
        rst         = 1'b1;
        rst_req_i   = 1'b1;
        init_done_i = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        // Power-on: request held 12 cycles after rst, all domains ready.
        rst    = 1'b0;
        mon_en = 1'b1;
        rise_at(cyc);
        repeat (12) @(posedge clk);
        #1;
        rst_req_i = 1'b0;
        fall_at(cyc, 3'b111);
        wait_idle();

        // Domain 1 never finishes init.
        do_seq(3, 3'b101, -1);
        // Abort while waiting on domain 1, then a clean restart.
        do_seq(5, 3'b101, 67);
        do_seq(4, 3'b111, -1);
        // One-cycle request pulse from RUN.
        do_seq(1, 3'b111, -1);

        // Randomized sequences, some aborted part-way.
        for (int k = 0; k < 10; k++) begin
            d = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) d = 3'b111;
            hold = $urandom_range(1, 15);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : -1;
            do_seq(hold, d, ab);
        end
        do_seq(2, 3'b111, -1);

        // Async rst in RUN, mid-cycle, observed without a clock edge.
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset();
        rst_req_i = 1'b1;
        exp_q.delete();
        q2.delete();
        n_model  = 0;
        n2_model = 0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        rise_at(cyc);
        d = 3'($urandom_range(0, 7));
        repeat (6) @(posedge clk);
        #1;
        init_done_i = d;
        rst_req_i   = 1'b0;
        fall_at(cyc, d);
        wait_idle();
        do_seq(1, 3'b111, -1);
        do_seq(2, 3'b111, -1);
        do_seq(3, 3'b011, -1);

        repeat (4) @(negedge clk);
        chk("sat_queue_drained", q2.size(), 0);
        chk("sat_final", int'(cnt2), (n2_model > 3) ? 3 : n2_model);
        chk("count_final", int'(rst_count_o), n_model);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
